dpwm_generator: RTL and testbench

DPWM_GENERATOR -- requirements
Module: dpwm_generator

---
 rtl/dpwm_pkg.sv | 26 ++
 rtl/dpwm_prescaler.sv | 35 +++
 rtl/dpwm_generator.sv | 142 ++++++++++++++
 tb/tb_dpwm_generator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_pkg.sv
// ----------------------------------------------------------------------------
// dpwm_pkg -- shared definitions for the digital PWM generator.
//   DUTY_W          width of duty / period counter values
//   PERIOD_DEFAULT  default PWM period in ticks
//   dt_state_e      dead-time FSM state encoding (used with DPWM_DEADTIME_EN)
//   saturate_duty   clamps a requested duty to the period length
// ----------------------------------------------------------------------------
package dpwm_pkg;

  localparam int DUTY_W         = 10;
  localparam int PERIOD_DEFAULT = 1000;

  typedef enum logic [2:0] {
    DT_OFF,
    DT_HIGH_ON,
    DT_DEAD_HL,
    DT_LOW_ON,
    DT_DEAD_LH
  } dt_state_e;

  function automatic logic [DUTY_W-1:0] saturate_duty(input logic [DUTY_W-1:0] value,
                                                      input logic [DUTY_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/dpwm_prescaler.sv
// ----------------------------------------------------------------------------
// dpwm_prescaler -- divides clk down to the PWM tick rate.
//   clk    system clock
//   reset  asynchronous, active-high reset
//   tick   high for one clk every DIV clks (while the count sits at DIV-1)
// ----------------------------------------------------------------------------
module dpwm_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // DIV = 1 still needs a one-bit counter; it simply stays at zero.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/dpwm_generator.sv
// ----------------------------------------------------------------------------
// dpwm_generator -- counter-compare PWM with a per-period shadow duty register
// and optional complementary output with dead time.
//   clk           system clock
//   reset         asynchronous, active-high reset
//   duty          requested duty in ticks (saturated to PERIOD)
//   pwm_out       registered PWM waveform
//   pwm_n         complementary waveform with dead time (DPWM_DEADTIME_EN only)
//   period_start  one-clk pulse on the first clk of each period
//   duty_applied  shadow duty in force for the current period
// Build option: define DPWM_DEADTIME_EN to add pwm_n and the dead-time FSM.
// ----------------------------------------------------------------------------
module dpwm_generator
  import dpwm_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEFAULT,
  parameter int DIV      = 50,
  parameter int DEADTIME = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
`ifdef DPWM_DEADTIME_EN
  output logic              pwm_n,
`endif
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_applied
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

  logic              tick;
  logic              wrap;
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] shadow;
  logic              pwm_raw;

  dpwm_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (cnt == CNT_LAST);

  // The shadow only loads at the wrap, so a duty change mid-period waits for
  // the next period; pwm_raw compares the pre-edge cnt/shadow pair, which keeps
  // the whole period window consistent even when shadow changes at the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      shadow       <= '0;
      period_start <= 1'b0;
      pwm_raw      <= 1'b0;
    end else begin
      period_start <= wrap;
      pwm_raw      <= (cnt < shadow);
      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (wrap) begin
        shadow <= saturate_duty(duty, DUTY_MAX);
      end
    end
  end

  assign duty_applied = shadow;

`ifdef DPWM_DEADTIME_EN
  localparam int            DW        = $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);

  dt_state_e     state;
  logic [DW-1:0] dead_cnt;

  // Outputs only go high when leaving a dead state, and both are already low
  // inside dead states, so the pair can never be high together. A reversal of
  // pwm_raw inside a dead interval restarts the interval toward the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= DT_OFF;
      dead_cnt <= '0;
      pwm_out  <= 1'b0;
      pwm_n    <= 1'b0;
    end else begin
      case (state)
        DT_OFF: begin
          state   <= DT_LOW_ON;
          pwm_out <= 1'b0;
          pwm_n   <= 1'b1;
        end
        DT_LOW_ON: begin
          if (pwm_raw) begin
            state    <= DT_DEAD_LH;
            dead_cnt <= '0;
            pwm_n    <= 1'b0;
          end
        end
        DT_HIGH_ON: begin
          if (!pwm_raw) begin
            state    <= DT_DEAD_HL;
            dead_cnt <= '0;
            pwm_out  <= 1'b0;
          end
        end
        DT_DEAD_LH: begin
          if (!pwm_raw) begin
            state    <= DT_DEAD_HL;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_LAST) begin
            state   <= DT_HIGH_ON;
            pwm_out <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        DT_DEAD_HL: begin
          if (pwm_raw) begin
            state    <= DT_DEAD_LH;
            dead_cnt <= '0;
          end else if (dead_cnt == DEAD_LAST) begin
            state <= DT_LOW_ON;
            pwm_n <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: begin
          state   <= DT_OFF;
          pwm_out <= 1'b0;
          pwm_n   <= 1'b0;
        end
      endcase
    end
  end
`else
  assign pwm_out = pwm_raw;
`endif

endmodule

// File: tb/tb_dpwm_generator.sv
// ----------------------------------------------------------------------------
// tb_dpwm_generator -- self-checking bench for dpwm_generator (PERIOD=1000,
// DIV=2). Each period's expected high time and sampled duty are queued when
// the stimulus for that period is driven and compared when period_start ends
// it. With DPWM_DEADTIME_EN the bench instead measures the dead intervals.
// ----------------------------------------------------------------------------
module tb_dpwm_generator;

  localparam int PERIOD   = 1000;
  localparam int DIV      = 2;
  localparam int DEADTIME = 4;
  localparam int PCLKS    = PERIOD * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] duty;
  logic       pwm_out;
  logic       period_start;
  logic [9:0] duty_applied;
`ifdef DPWM_DEADTIME_EN
  logic       pwm_n;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dpwm_generator #(.PERIOD(PERIOD), .DIV(DIV), .DEADTIME(DEADTIME)) dut (
    .clk          (clk),
    .reset        (reset),
    .duty         (duty),
    .pwm_out      (pwm_out),
`ifdef DPWM_DEADTIME_EN
    .pwm_n        (pwm_n),
`endif
    .period_start (period_start),
    .duty_applied (duty_applied)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ps(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!period_start && n < limit);
    check("period_start_seen", int'(period_start), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

`ifndef DPWM_DEADTIME_EN
  typedef struct {
    int hi;       // expected pwm_out-high clks in the period
    int cur;      // shadow in force during the period
    int applied;  // shadow loaded at the wrap that ends the period
  } exp_t;

  exp_t sb[$];
  int   m_shadow;

  // Queue the expectation for the period now running, change duty mid_at clks
  // into it, and follow it to its closing period_start.
  task automatic run_period(input int d_end, input int mid_at);
    exp_t e;
    e.cur     = m_shadow;
    e.hi      = m_shadow * DIV;
    e.applied = (d_end > PERIOD) ? PERIOD : d_end;
    sb.push_back(e);
    repeat (mid_at) @(posedge clk);
    #1;
    duty = 10'(d_end);
    wait_ps(2 * PCLKS);
    m_shadow = e.applied;
  endtask

  // Period monitor: a period's window runs from the clk after one
  // period_start through the next period_start clk (pwm_out lags cnt by 1).
  initial begin
    int         hi_cnt;
    int         len_cnt;
    logic [9:0] last_applied;
    exp_t       e;
    hi_cnt = 0;
    len_cnt = 0;
    last_applied = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi_cnt  = 0;
        len_cnt = 0;
      end else begin
        hi_cnt += int'(pwm_out);
        len_cnt++;
        if (period_start) begin
          check("sb_nonempty", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("high_clks", hi_cnt, e.hi);
            check("period_clks", len_cnt, PCLKS);
            check("applied_before_wrap", int'(last_applied), e.cur);
            check("applied_at_wrap", int'(duty_applied), e.applied);
          end
          hi_cnt  = 0;
          len_cnt = 0;
        end
        last_applied = duty_applied;
      end
    end
  end

  initial begin
    m_shadow = 0;
    reset = 1'b1;
    duty  = 10'd250;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty_applied", int'(duty_applied), 0);
    @(negedge clk); #1;
    reset = 1'b0;

    run_period(250, 100);    // first period after reset: all low
    run_period(250, 100);    // 250 ticks high
    run_period(0, 1000);     // mid-period change ignored: still 250 ticks
    run_period(1000, 1000);  // duty 0: all low
    run_period(1023, 1000);  // duty 1000: all high
    run_period(100, 1000);   // saturated 1000: all high
    run_period(600, 1000);   // 100 ticks; 600 queued mid-period
    run_period(800, 1000);   // 600 ticks

    // Shadow is now 800; pulse reset when cnt reaches 500.
    repeat (1000) @(posedge clk);
    #1;
    check("pre_reset_pwm_high", int'(pwm_out), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_period_start", int'(period_start), 0);
    check("async_reset_applied", int'(duty_applied), 0);
    @(negedge clk); #1;
    reset = 1'b0;
    m_shadow = 0;

    run_period(800, 100);    // all low: shadow cleared by reset
    run_period(800, 100);    // 800 ticks high

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

`else
  bit armed = 1'b0;
  int runs[$];
  int overlap = 0;

  // Records the length of each interval in which both outputs are low.
  initial begin
    int run_len;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (pwm_out && pwm_n) overlap++;
      if (armed) begin
        if (!pwm_out && !pwm_n) begin
          run_len++;
        end else if (run_len > 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    duty  = 10'd300;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm_out", int'(pwm_out), 0);
    check("rst_pwm_n", int'(pwm_n), 0);
    check("rst_period_start", int'(period_start), 0);
    check("rst_duty_applied", int'(duty_applied), 0);
    @(negedge clk); #1;
    reset = 1'b0;

    wait_ps(2 * PCLKS);
    check("applied_300", int'(duty_applied), 300);
    check("low_on_pwm_n", int'(pwm_n), 1);
    check("low_on_pwm_out", int'(pwm_out), 0);
    armed = 1'b1;
    wait_ps(2 * PCLKS);
    wait_ps(2 * PCLKS);

    check("dead_run_count", runs.size(), 4);
    for (int i = 0; i < runs.size(); i++) begin
      check("dead_run_len", runs[i], DEADTIME);
    end
    check("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`endif

endmodule
